axi_burst_mem_slave: RTL and testbench
======================================

AXI_BURST_MEM_SLAVE -- requirements
Module: axi_burst_mem_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, byte-address width of AW/AR channels.
REQ-002 Parameter DATA_WIDTH, default 128, data-bus width in bits; beat size is DATA_WIDTH/8 bytes.
REQ-003 Parameter DEPTH, default 20, number of DATA_WIDTH-bit storage words.
REQ-004 s_axi_aclk  in  1  single clock; all logic rising-edge.
REQ-005 s_axi_aresetn  in  1  asynchronous, active-low reset.
REQ-006 s_axi_arvalid / s_axi_arready  in / out  1 / 1  read-address handshake.
REQ-007 s_axi_araddr  in  ADDR_WIDTH  read burst start byte address.
REQ-008 s_axi_arlen  in  8  read beats minus one.
REQ-009 s_axi_arsize  in  3  read beat size, ignored.
REQ-010 s_axi_arburst  in  2  read burst type.
REQ-011 s_axi_rvalid / s_axi_rready  out / in  1 / 1  read-data handshake.
REQ-012 s_axi_rdata  out  DATA_WIDTH  read beat data.
REQ-013 s_axi_rlast  out  1  final read beat.
REQ-014 s_axi_awvalid / s_axi_awready  in / out  1 / 1  write-address handshake.
REQ-015 s_axi_awaddr  in  ADDR_WIDTH  write burst start byte address.
REQ-016 s_axi_awlen  in  8  write beats minus one.
REQ-017 s_axi_awsize  in  3  write beat size, ignored.
REQ-018 s_axi_awburst  in  2  write burst type.
REQ-019 s_axi_wvalid / s_axi_wready  in / out  1 / 1  write-data handshake.
REQ-020 s_axi_wdata  in  DATA_WIDTH  write beat data.
REQ-021 s_axi_wstrb  in  DATA_WIDTH/8  byte-lane enables.
REQ-022 s_axi_wlast  in  1  final write beat flag, informational.
REQ-023 s_axi_bvalid / s_axi_bready  out / in  1 / 1  write-response handshake.

Function
REQ-024 Word index SHALL be addr >> log2(DATA_WIDTH/8); each beat increments the index by 1; every burst type SHALL be treated as INCR.
REQ-025 Read FSM states R_IDLE, R_DATA: arready=1 only in R_IDLE; an AR handshake latches the index and arlen+1 beats and moves to R_DATA; rvalid SHALL rise exactly one cycle after the AR handshake.
REQ-026 In R_DATA, rdata/rlast SHALL be registered and held stable while rvalid=1 and rready=0; an R handshake advances to the next word, and the next beat is valid on the following cycle.
REQ-027 rlast=1 only on beat arlen+1; the handshake of that beat SHALL return to R_IDLE, with arready=1 on the next cycle.
REQ-028 Write FSM states W_IDLE, W_DATA, W_RESP: awready=1 only in W_IDLE; wready=1 only in W_DATA; a W handshake writes only the bytes whose wstrb bit is 1.
REQ-029 The burst SHALL end on handshake awlen+1 regardless of wlast; the FSM then enters W_RESP, bvalid=1 on the next cycle and held until bready; the B handshake returns to W_IDLE.
REQ-030 Index >= DEPTH: read beats SHALL return all zeros; write beats SHALL be accepted and discarded; the handshake count is unaffected and there is no wrap-around.
REQ-031 Read and write channels are independent; a same-cycle read and write of one word SHALL return the old data (read-before-write).
REQ-032 Storage SHALL be an array named mem [0:DEPTH-1] of DATA_WIDTH bits, hierarchically accessible for bench preload and inspection.

Reset
REQ-033 While s_axi_aresetn=0: arready=1, awready=1, rvalid=0, rlast=0, rdata=0, wready=0, bvalid=0; both FSMs are idle.
REQ-034 Reset mid-burst SHALL abandon the burst without issuing a response; mem contents SHALL NOT be cleared.

Structure
REQ-035 Package axi_mem_pkg SHALL hold the read/write state enums and the AXI burst-type constants (FIXED/INCR/WRAP).
REQ-036 Byte-enabled storage SHALL be a single sub-module, axi_mem_bank: one write port and one registered read port.

Verification
REQ-037 Preload mem[4]=128'h0123_4567_89AB_CDEF_0011_2233_4455_6677; read araddr=64, arlen=0 -> one beat with that data, rlast=1, rvalid one cycle after AR.
REQ-038 Write awaddr=192, awlen=3, wstrb=16'hFFFF, data D0..D3 -> mem[12..15]=D0..D3; exactly one bvalid, one cycle after the 4th beat.
REQ-039 mem[12] all ones; write awlen=0, wstrb=16'h00FF, wdata=0 -> mem[12]=128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000.
REQ-040 Read araddr=64, arlen=7, rready toggling 1/0 -> 8 beats mem[4..11], rdata stable during stalls, rlast only on the 8th.
REQ-041 Read/write araddr=awaddr=320 (index 20) -> rdata=0, write discarded, bvalid issued; reset asserted after the 2nd beat of a 4-beat write -> no bvalid, awready=1 after release, already-written words kept.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// Shared types for the AXI burst memory slave: channel FSM states and AXI burst encodings.
package axi_mem_pkg;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wr_state_e;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/axi_mem_bank.sv
// Byte-enabled word storage with one write port and one registered read port.
// Indices at or beyond DEPTH are ignored on write and read back as zero.
module axi_mem_bank #(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned DEPTH      = 20,
   parameter int unsigned IDX_WIDTH  = 64
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_we,
   input  logic [IDX_WIDTH-1:0]    i_waddr,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_wstrb,
   input  logic                    i_re,
   input  logic [IDX_WIDTH-1:0]    i_raddr,
   output logic [DATA_WIDTH-1:0]   o_rdata
);

   localparam int unsigned NBYTES = DATA_WIDTH / 8;
   localparam int unsigned SEL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] r_rdata;

   logic             w_wr_hit;
   logic             w_rd_hit;
   logic [SEL_W-1:0] w_wsel;
   logic [SEL_W-1:0] w_rsel;

   assign w_wr_hit = (i_waddr < IDX_WIDTH'(DEPTH));
   assign w_rd_hit = (i_raddr < IDX_WIDTH'(DEPTH));
   assign w_wsel   = i_waddr[SEL_W-1:0];
   assign w_rsel   = i_raddr[SEL_W-1:0];

   // Contents are deliberately not reset so they survive an interface reset.
   always_ff @(posedge i_clk) begin
      if (i_we && w_wr_hit) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (i_wstrb[b]) begin
               mem[w_wsel][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= w_rd_hit ? mem[w_rsel] : '0;
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst memory slave: independent read and write FSMs over a word-addressed bank.
// All burst types are handled as INCR; beats past DEPTH read zero and drop writes.
module axi_burst_mem_slave #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned DEPTH      = 20
) (
   input  logic                    s_axi_aclk,
   input  logic                    s_axi_aresetn,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [7:0]              s_axi_arlen,
   input  logic [2:0]              s_axi_arsize,
   input  logic [1:0]              s_axi_arburst,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic                    s_axi_rlast,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [7:0]              s_axi_awlen,
   input  logic [2:0]              s_axi_awsize,
   input  logic [1:0]              s_axi_awburst,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wlast,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready
);

   import axi_mem_pkg::*;

   localparam int unsigned OFF_BITS = $clog2(DATA_WIDTH / 8);

   rd_state_e             r_rstate;
   logic                  r_arready;
   logic                  r_rvalid;
   logic                  r_rlast;
   logic [ADDR_WIDTH-1:0] r_ridx;
   logic [7:0]            r_rcnt;

   wr_state_e             r_wstate;
   logic                  r_awready;
   logic                  r_wready;
   logic                  r_bvalid;
   logic [ADDR_WIDTH-1:0] r_widx;
   logic [7:0]            r_wcnt;

   logic                  w_ar_hs;
   logic                  w_r_hs;
   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_b_hs;
   logic                  w_rd_en;
   logic [ADDR_WIDTH-1:0] w_ar_idx;
   logic [ADDR_WIDTH-1:0] w_aw_idx;
   logic [ADDR_WIDTH-1:0] w_rd_idx;
   logic                  w_unused;

   assign w_ar_hs  = s_axi_arvalid & r_arready;
   assign w_r_hs   = r_rvalid & s_axi_rready;
   assign w_aw_hs  = s_axi_awvalid & r_awready;
   assign w_w_hs   = s_axi_wvalid & r_wready;
   assign w_b_hs   = r_bvalid & s_axi_bready;
   assign w_ar_idx = s_axi_araddr >> OFF_BITS;
   assign w_aw_idx = s_axi_awaddr >> OFF_BITS;

   // Fetch the first word on AR, the next word on every non-final R handshake.
   assign w_rd_en  = w_ar_hs | (w_r_hs & ~r_rlast);
   assign w_rd_idx = w_ar_hs ? w_ar_idx : r_ridx + ADDR_WIDTH'(1);

   assign w_unused = ^{s_axi_arsize, s_axi_awsize, s_axi_arburst, s_axi_awburst, s_axi_wlast};

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b1;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_ridx    <= '0;
         r_rcnt    <= '0;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (w_ar_hs) begin
                  r_rstate  <= R_DATA;
                  r_arready <= 1'b0;
                  r_rvalid  <= 1'b1;
                  r_rlast   <= (s_axi_arlen == 8'd0);
                  r_ridx    <= w_ar_idx;
                  r_rcnt    <= s_axi_arlen;
               end
            end
            R_DATA: begin
               if (w_r_hs) begin
                  if (r_rlast) begin
                     r_rstate  <= R_IDLE;
                     r_arready <= 1'b1;
                     r_rvalid  <= 1'b0;
                     r_rlast   <= 1'b0;
                  end else begin
                     r_ridx  <= r_ridx + ADDR_WIDTH'(1);
                     r_rcnt  <= r_rcnt - 8'd1;
                     r_rlast <= (r_rcnt == 8'd1);
                  end
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   // Burst length comes from awlen alone; wlast is not trusted.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b1;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_widx    <= '0;
         r_wcnt    <= '0;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (w_aw_hs) begin
                  r_wstate  <= W_DATA;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b1;
                  r_widx    <= w_aw_idx;
                  r_wcnt    <= s_axi_awlen;
               end
            end
            W_DATA: begin
               if (w_w_hs) begin
                  r_widx <= r_widx + ADDR_WIDTH'(1);
                  r_wcnt <= r_wcnt - 8'd1;
                  if (r_wcnt == 8'd0) begin
                     r_wstate <= W_RESP;
                     r_wready <= 1'b0;
                     r_bvalid <= 1'b1;
                  end
               end
            end
            W_RESP: begin
               if (w_b_hs) begin
                  r_wstate  <= W_IDLE;
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
               end
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   axi_mem_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_WIDTH  (ADDR_WIDTH)
   ) u_bank (
      .i_clk   (s_axi_aclk),
      .i_rst_n (s_axi_aresetn),
      .i_we    (w_w_hs),
      .i_waddr (r_widx),
      .i_wdata (s_axi_wdata),
      .i_wstrb (s_axi_wstrb),
      .i_re    (w_rd_en),
      .i_raddr (w_rd_idx),
      .o_rdata (s_axi_rdata)
   );

   assign s_axi_arready = r_arready;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rlast   = r_rlast;
   assign s_axi_awready = r_awready;
   assign s_axi_wready  = r_wready;
   assign s_axi_bvalid  = r_bvalid;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Randomised bench for axi_burst_mem_slave against a word-array reference model.
module tb_axi_burst_mem_slave;

   localparam int unsigned DEPTH = 20;
   localparam int unsigned TMO   = 200;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         s_axi_arvalid, s_axi_arready;
   logic [63:0]  s_axi_araddr;
   logic [7:0]   s_axi_arlen;
   logic [2:0]   s_axi_arsize;
   logic [1:0]   s_axi_arburst;
   logic         s_axi_rvalid, s_axi_rready, s_axi_rlast;
   logic [127:0] s_axi_rdata;
   logic         s_axi_awvalid, s_axi_awready;
   logic [63:0]  s_axi_awaddr;
   logic [7:0]   s_axi_awlen;
   logic [2:0]   s_axi_awsize;
   logic [1:0]   s_axi_awburst;
   logic         s_axi_wvalid, s_axi_wready, s_axi_wlast;
   logic [127:0] s_axi_wdata;
   logic [15:0]  s_axi_wstrb;
   logic         s_axi_bvalid, s_axi_bready;

   always #5 clk = ~clk;

   axi_burst_mem_slave #(
      .ADDR_WIDTH (64),
      .DATA_WIDTH (128),
      .DEPTH      (DEPTH)
   ) dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rst_n),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arlen   (s_axi_arlen),
      .s_axi_arsize  (s_axi_arsize),
      .s_axi_arburst (s_axi_arburst),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rlast   (s_axi_rlast),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awlen   (s_axi_awlen),
      .s_axi_awsize  (s_axi_awsize),
      .s_axi_awburst (s_axi_awburst),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wlast   (s_axi_wlast),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready)
   );

   logic [127:0] model_mem [0:DEPTH-1];
   logic [127:0] wbuf_data [0:255];
   logic [15:0]  wbuf_strb [0:255];
   logic [127:0] rd_data   [0:255];
   logic         rd_last   [0:255];
   int unsigned  n_pass  = 0;
   int unsigned  n_total = 0;

   function automatic logic [127:0] model_read(input logic [63:0] idx);
      logic [127:0] v;
      v = '0;
      if (idx < 64'(DEPTH)) v = model_mem[idx[4:0]];
      return v;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic mem_errors(output int unsigned errs);
      errs = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (dut.u_bank.mem[i] !== model_mem[i]) errs++;
      end
   endtask

   // Drives one write burst from wbuf_*, updates the model, then collects the response.
   task automatic axi_write(input logic [63:0] addr, input int unsigned len,
                            output int unsigned b_lat, output int unsigned b_cnt);
      int unsigned cyc;
      logic [63:0] idx, cur;
      idx = addr >> 4;
      s_axi_awaddr  = addr;
      s_axi_awlen   = len[7:0];
      s_axi_awsize  = 3'd4;
      s_axi_awburst = 2'($urandom_range(0, 3));
      s_axi_awvalid = 1'b1;
      cyc = 0;
      while (!s_axi_awready && cyc < TMO) begin @(posedge clk); #1; cyc++; end
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         s_axi_wvalid = 1'b1;
         s_axi_wdata  = wbuf_data[i];
         s_axi_wstrb  = wbuf_strb[i];
         s_axi_wlast  = (i == int'(len));
         cyc = 0;
         while (!s_axi_wready && cyc < TMO) begin @(posedge clk); #1; cyc++; end
         @(posedge clk); #1;
         cur = idx + 64'(i);
         if (cur < 64'(DEPTH)) begin
            for (int b = 0; b < 16; b++) begin
               if (wbuf_strb[i][b]) model_mem[cur[4:0]][b*8 +: 8] = wbuf_data[i][b*8 +: 8];
            end
         end
      end
      s_axi_wvalid = 1'b0;
      s_axi_wlast  = 1'b0;
      b_lat = 0;
      while (!s_axi_bvalid && b_lat < TMO) begin @(posedge clk); #1; b_lat++; end
      b_cnt = 0;
      s_axi_bready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (s_axi_bvalid) b_cnt++;
         @(posedge clk); #1;
      end
      s_axi_bready = 1'b0;
   endtask

   // Runs one read burst into rd_*; with stall set, rready alternates starting low.
   task automatic axi_read(input logic [63:0] addr, input int unsigned len, input bit stall,
                           output int unsigned ar_lat, output int unsigned nbeats,
                           output int unsigned unstable, output int unsigned gaps);
      int unsigned cyc;
      bit held, tog;
      logic [127:0] h_data;
      logic h_last;
      s_axi_araddr  = addr;
      s_axi_arlen   = len[7:0];
      s_axi_arsize  = 3'd4;
      s_axi_arburst = 2'($urandom_range(0, 3));
      s_axi_arvalid = 1'b1;
      cyc = 0;
      while (!s_axi_arready && cyc < TMO) begin @(posedge clk); #1; cyc++; end
      @(posedge clk); #1;
      s_axi_arvalid = 1'b0;
      ar_lat = 0;
      while (!s_axi_rvalid && ar_lat < TMO) begin @(posedge clk); #1; ar_lat++; end
      nbeats = 0; unstable = 0; gaps = 0; held = 0; tog = 0; cyc = 0;
      h_data = '0; h_last = 1'b0;
      while (nbeats <= len && cyc < TMO) begin
         if (s_axi_rvalid) begin
            if (held && (s_axi_rdata !== h_data || s_axi_rlast !== h_last)) unstable++;
            s_axi_rready = !stall || tog;
            tog = ~tog;
            if (s_axi_rready) begin
               rd_data[nbeats] = s_axi_rdata;
               rd_last[nbeats] = s_axi_rlast;
               nbeats++;
               held = 0;
            end else begin
               held = 1; h_data = s_axi_rdata; h_last = s_axi_rlast;
            end
         end else begin
            s_axi_rready = 1'b0;
            gaps++;
         end
         @(posedge clk); #1; cyc++;
      end
      s_axi_rready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if ({s_axi_arready, s_axi_awready, s_axi_rvalid, s_axi_rlast, s_axi_wready, s_axi_bvalid}
          !== 6'b110000) begin
         $display("FAIL reset_ctrl: got %b want 110000", {s_axi_arready, s_axi_awready,
                  s_axi_rvalid, s_axi_rlast, s_axi_wready, s_axi_bvalid});
      end else n_pass++;
      n_total++;
      if (s_axi_rdata !== 128'd0) $display("FAIL reset_rdata: got %h want 0", s_axi_rdata);
      else n_pass++;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single_read();
      int unsigned bl, bc, al, nb, us, gp, errs;
      for (int i = 0; i < DEPTH; i++) begin
         wbuf_data[i] = rand128();
         wbuf_strb[i] = 16'hFFFF;
      end
      axi_write(64'd0, DEPTH - 1, bl, bc);
      wbuf_data[0] = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
      axi_write(64'd64, 0, bl, bc);
      mem_errors(errs);
      n_total++;
      if (errs != 0) $display("FAIL preload_mem: got %0d bad words want 0", errs);
      else n_pass++;
      axi_read(64'd64, 0, 1'b0, al, nb, us, gp);
      n_total++;
      if (al != 0) $display("FAIL single_ar_latency: got %0d want 0", al); else n_pass++;
      n_total++;
      if (nb != 1 || rd_data[0] !== 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677)
         $display("FAIL single_rdata: got %h (beats %0d) want 0123456789abcdef0011223344556677",
                  rd_data[0], nb);
      else n_pass++;
      n_total++;
      if (rd_last[0] !== 1'b1) $display("FAIL single_rlast: got %b want 1", rd_last[0]);
      else n_pass++;
      n_total++;
      if ({s_axi_rvalid, s_axi_arready} !== 2'b01)
         $display("FAIL single_after: got rvalid/arready %b want 01",
                  {s_axi_rvalid, s_axi_arready});
      else n_pass++;
   endtask

   task automatic test_burst_write();
      int unsigned bl, bc;
      logic [127:0] d [0:3];
      for (int i = 0; i < 4; i++) begin
         d[i] = rand128();
         wbuf_data[i] = d[i];
         wbuf_strb[i] = 16'hFFFF;
      end
      axi_write(64'd192, 3, bl, bc);
      n_total++;
      if (bl != 0 || bc != 1) $display("FAIL burst_bresp: got lat %0d count %0d want 0 1", bl, bc);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (dut.u_bank.mem[12+i] !== d[i])
            $display("FAIL burst_mem%0d: got %h want %h", 12 + i, dut.u_bank.mem[12+i], d[i]);
         else n_pass++;
      end
   endtask

   task automatic test_strobe();
      int unsigned bl, bc;
      wbuf_data[0] = '1;
      wbuf_strb[0] = 16'hFFFF;
      axi_write(64'd192, 0, bl, bc);
      wbuf_data[0] = '0;
      wbuf_strb[0] = 16'h00FF;
      axi_write(64'd192, 0, bl, bc);
      n_total++;
      if (dut.u_bank.mem[12] !== 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000)
         $display("FAIL strobe_mem12: got %h want ffffffffffffffff0000000000000000",
                  dut.u_bank.mem[12]);
      else n_pass++;
   endtask

   task automatic test_stall_read();
      int unsigned al, nb, us, gp, bad_d, bad_l;
      axi_read(64'd64, 7, 1'b1, al, nb, us, gp);
      bad_d = 0; bad_l = 0;
      for (int i = 0; i < 8; i++) begin
         if (rd_data[i] !== model_mem[4+i]) bad_d++;
         if (rd_last[i] !== (i == 7)) bad_l++;
      end
      n_total++;
      if (nb != 8 || bad_d != 0)
         $display("FAIL stall_data: got %0d beats %0d bad want 8 beats 0 bad", nb, bad_d);
      else n_pass++;
      n_total++;
      if (bad_l != 0) $display("FAIL stall_rlast: got %0d misplaced want 0", bad_l); else n_pass++;
      n_total++;
      if (us != 0) $display("FAIL stall_stable: got %0d changes want 0", us); else n_pass++;
      n_total++;
      if (al != 0 || gp != 0) $display("FAIL stall_timing: got lat %0d gaps %0d want 0 0", al, gp);
      else n_pass++;
   endtask

   task automatic test_out_of_range();
      int unsigned al, nb, us, gp, bl, bc, errs;
      axi_read(64'd320, 0, 1'b0, al, nb, us, gp);
      n_total++;
      if (nb != 1 || rd_data[0] !== 128'd0 || rd_last[0] !== 1'b1)
         $display("FAIL oor_read: got %h last %b beats %0d want 0 1 1", rd_data[0], rd_last[0], nb);
      else n_pass++;
      for (int i = 0; i < 2; i++) begin
         wbuf_data[i] = rand128();
         wbuf_strb[i] = 16'hFFFF;
      end
      axi_write(64'd320, 1, bl, bc);
      n_total++;
      if (bl != 0 || bc != 1) $display("FAIL oor_bresp: got lat %0d count %0d want 0 1", bl, bc);
      else n_pass++;
      // Straddles the top word: first beat lands, second is dropped.
      for (int i = 0; i < 2; i++) wbuf_data[i] = rand128();
      axi_write(64'd304, 1, bl, bc);
      axi_read(64'd304, 2, 1'b0, al, nb, us, gp);
      n_total++;
      if (nb != 3 || rd_data[0] !== model_mem[19] || rd_data[1] !== 128'd0 || rd_data[2] !== 128'd0)
         $display("FAIL oor_straddle: got %h %h %h want %h 0 0", rd_data[0], rd_data[1],
                  rd_data[2], model_mem[19]);
      else n_pass++;
      mem_errors(errs);
      n_total++;
      if (errs != 0) $display("FAIL oor_mem: got %0d bad words want 0", errs); else n_pass++;
   endtask

   task automatic test_reset_mid_burst();
      int unsigned cyc, bcnt, errs;
      logic [127:0] old18;
      old18 = model_mem[18];
      for (int i = 0; i < 4; i++) begin
         wbuf_data[i] = rand128();
         wbuf_strb[i] = 16'hFFFF;
      end
      s_axi_awaddr = 64'd256; s_axi_awlen = 8'd3; s_axi_awvalid = 1'b1;
      cyc = 0;
      while (!s_axi_awready && cyc < TMO) begin @(posedge clk); #1; cyc++; end
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         s_axi_wvalid = 1'b1; s_axi_wdata = wbuf_data[i]; s_axi_wstrb = wbuf_strb[i];
         cyc = 0;
         while (!s_axi_wready && cyc < TMO) begin @(posedge clk); #1; cyc++; end
         @(posedge clk); #1;
         model_mem[16+i] = wbuf_data[i];
      end
      s_axi_wvalid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      s_axi_bready = 1'b1;
      bcnt = 0;
      for (int k = 0; k < 5; k++) begin
         if (s_axi_bvalid) bcnt++;
         @(posedge clk); #1;
      end
      s_axi_bready = 1'b0;
      n_total++;
      if (bcnt != 0) $display("FAIL rstmid_bvalid: got %0d cycles want 0", bcnt); else n_pass++;
      n_total++;
      if ({s_axi_awready, s_axi_wready} !== 2'b10)
         $display("FAIL rstmid_idle: got awready/wready %b want 10", {s_axi_awready, s_axi_wready});
      else n_pass++;
      n_total++;
      if (dut.u_bank.mem[16] !== wbuf_data[0] || dut.u_bank.mem[17] !== wbuf_data[1] ||
          dut.u_bank.mem[18] !== old18)
         $display("FAIL rstmid_kept: got %h %h %h want %h %h %h", dut.u_bank.mem[16],
                  dut.u_bank.mem[17], dut.u_bank.mem[18], wbuf_data[0], wbuf_data[1], old18);
      else n_pass++;
      mem_errors(errs);
      n_total++;
      if (errs != 0) $display("FAIL rstmid_mem: got %0d bad words want 0", errs); else n_pass++;
   endtask

   // Same-edge AR and W on word 2: the read must see the pre-write contents.
   task automatic test_back_to_back();
      logic [127:0] old_w, new_w;
      int unsigned cyc, errs;
      old_w = model_mem[2];
      new_w = rand128();
      s_axi_awaddr = 64'd32; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
      cyc = 0;
      while (!s_axi_awready && cyc < TMO) begin @(posedge clk); #1; cyc++; end
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0;
      s_axi_wvalid = 1'b1; s_axi_wdata = new_w; s_axi_wstrb = 16'hFFFF; s_axi_wlast = 1'b1;
      s_axi_araddr = 64'd32; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
      @(posedge clk); #1;
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
      model_mem[2] = new_w;
      n_total++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== old_w)
         $display("FAIL rbw_rdata: got %h valid %b want %h 1", s_axi_rdata, s_axi_rvalid, old_w);
      else n_pass++;
      n_total++;
      if (s_axi_bvalid !== 1'b1) $display("FAIL rbw_bvalid: got %b want 1", s_axi_bvalid);
      else n_pass++;
      s_axi_rready = 1'b1; s_axi_bready = 1'b1;
      @(posedge clk); #1;
      s_axi_rready = 1'b0; s_axi_bready = 1'b0;
      n_total++;
      if ({s_axi_arready, s_axi_awready, s_axi_rvalid, s_axi_bvalid} !== 4'b1100)
         $display("FAIL rbw_idle: got %b want 1100",
                  {s_axi_arready, s_axi_awready, s_axi_rvalid, s_axi_bvalid});
      else n_pass++;
      mem_errors(errs);
      n_total++;
      if (errs != 0) $display("FAIL rbw_mem: got %0d bad words want 0", errs); else n_pass++;
   endtask

   task automatic test_random();
      int unsigned len, al, nb, us, gp, bl, bc, bad, errs;
      logic [63:0] addr, idx;
      for (int t = 0; t < 30; t++) begin
         idx  = 64'($urandom_range(0, DEPTH + 3));
         addr = (idx << 4) | 64'($urandom_range(0, 15));
         len  = $urandom_range(0, 6);
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i <= int'(len); i++) begin
               wbuf_data[i] = rand128();
               wbuf_strb[i] = 16'($urandom);
            end
            axi_write(addr, len, bl, bc);
            n_total++;
            if (bl != 0 || bc != 1)
               $display("FAIL rand_bresp%0d: got lat %0d count %0d want 0 1", t, bl, bc);
            else n_pass++;
         end else begin
            axi_read(addr, len, 1'($urandom_range(0, 1)), al, nb, us, gp);
            bad = 0;
            for (int i = 0; i <= int'(len); i++) begin
               if (rd_data[i] !== model_read(idx + 64'(i))) bad++;
               if (rd_last[i] !== (i == int'(len))) bad++;
            end
            n_total++;
            if (nb != len + 1 || bad != 0 || us != 0 || al != 0)
               $display("FAIL rand_read%0d: got beats %0d bad %0d unstable %0d lat %0d want %0d 0 0 0",
                        t, nb, bad, us, al, len + 1);
            else n_pass++;
         end
      end
      mem_errors(errs);
      n_total++;
      if (errs != 0) $display("FAIL rand_mem: got %0d bad words want 0", errs); else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0;
      s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
      s_axi_arburst = 2'b01; s_axi_rready = 1'b0;
      s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
      s_axi_awburst = 2'b01; s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
      s_axi_wlast = 1'b0; s_axi_bready = 1'b0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      test_reset();
      test_single_read();
      test_burst_write();
      test_strobe();
      test_stall_read();
      test_out_of_range();
      test_reset_mid_burst();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
